// File: rtl/dmem_responder.sv
// Multi-cycle RV32I data-memory responder: one request at a time, LATENCY wait states, 1-cycle response.
// Optional fault reporting (misaligned / out-of-range / unsupported size) enabled by defining DMEM_ERR_EN.
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        stall
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      r_state, w_state_next;
   logic [3:0]  r_cnt, w_cnt_next;
   logic        r_we;
   logic [2:0]  r_size;
   logic [31:0] r_addr, r_wdata;
   logic        w_accept, w_enter_resp;

   logic        w_we;
   logic [2:0]  w_size;
   logic [31:0] w_addr, w_wdata;
   logic [1:0]  w_sz, w_lane;
   logic        w_uns, w_bad_size, w_err;
   logic [3:0]  w_be;
   logic [31:0] w_wlanes;
   logic [AW-1:0] w_idx;
   logic        w_commit, w_rd_en;

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rd_word;
   logic        r_fmt_zero, r_fmt_uns, r_rsp_err;
   logic [1:0]  r_fmt_sz, r_fmt_lane;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign req_ready = (r_state == S_IDLE) & rst;
   assign w_accept  = req_valid & req_ready;
   assign rsp_valid = (r_state == S_RESP);
   assign stall     = req_valid & ~rsp_valid;
   assign rsp_err   = r_rsp_err;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_enter_resp = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (LATENCY == 0) begin
                  w_state_next = S_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_next = S_WAIT;
                  w_cnt_next   = 4'(LATENCY - 1);
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_next = S_RESP;
               w_enter_resp = 1'b1;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         S_RESP:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // With zero latency the array is accessed on the accept edge, before the request is latched.
   assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
   assign w_size  = (r_state == S_IDLE) ? req_size  : r_size;
   assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
   assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

   always_comb begin
      w_sz       = SZ_W;
      w_uns      = 1'b0;
      w_bad_size = 1'b0;
      case (w_size)
         3'b000:  w_sz = SZ_B;
         3'b001:  w_sz = SZ_H;
         3'b010:  w_sz = SZ_W;
         3'b100:  begin w_sz = w_we ? SZ_W : SZ_B; w_uns = ~w_we; w_bad_size = w_we; end
         3'b101:  begin w_sz = w_we ? SZ_W : SZ_H; w_uns = ~w_we; w_bad_size = w_we; end
         default: w_bad_size = 1'b1;
      endcase
   end

`ifdef DMEM_ERR_EN
   assign w_err = w_bad_size
                | ((w_sz == SZ_H) & w_addr[0])
                | ((w_sz == SZ_W) & (w_addr[1:0] != 2'b00))
                | (|w_addr[31:AW+2]);
`else
   logic w_unused;
   assign w_unused = ^{w_addr[31:AW+2], w_bad_size};
   assign w_err    = 1'b0;
`endif

   assign w_idx  = w_addr[2 +: AW];
   assign w_lane = (w_sz == SZ_B) ? w_addr[1:0] :
                   (w_sz == SZ_H) ? {w_addr[1], 1'b0} : 2'b00;

   always_comb begin
      w_be     = 4'b1111;
      w_wlanes = w_wdata;
      if (w_sz == SZ_B) begin
         w_be     = 4'b0001 << w_lane;
         w_wlanes = {4{w_wdata[7:0]}};
      end else if (w_sz == SZ_H) begin
         w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
         w_wlanes = {2{w_wdata[15:0]}};
      end
   end

   // Gating with rst drops a store whose commit edge coincides with reset.
   assign w_commit = w_enter_resp & w_we  & ~w_err & rst;
   assign w_rd_en  = w_enter_resp & ~w_we & ~w_err & rst;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (w_commit && w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
      if (w_rd_en) r_rd_word <= r_mem[w_idx];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_we       <= 1'b0;
         r_size     <= 3'd0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_fmt_zero <= 1'b1;
         r_fmt_uns  <= 1'b0;
         r_fmt_sz   <= SZ_W;
         r_fmt_lane <= 2'd0;
         r_rsp_err  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         if (w_enter_resp) begin
            r_fmt_zero <= w_we | w_err;
            r_fmt_uns  <= w_uns;
            r_fmt_sz   <= w_sz;
            r_fmt_lane <= w_lane;
            r_rsp_err  <= w_err;
         end
      end
   end

   // Load formatting sits after the registered array read so the raw word stays a plain RAM output.
   assign w_byte = r_rd_word[{r_fmt_lane, 3'b000} +: 8];
   assign w_half = r_fmt_lane[1] ? r_rd_word[31:16] : r_rd_word[15:0];

   always_comb begin
      rsp_rdata = 32'd0;
      if (!r_fmt_zero) begin
         case (r_fmt_sz)
            SZ_B:    rsp_rdata = r_fmt_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    rsp_rdata = r_fmt_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: rsp_rdata = r_rd_word;
         endcase
      end
   end
endmodule
